average_frame_gen: RTL and testbench

//  Upstream framer for the averaging stage. Takes a continuous stream of signed phase samples.

---
 rtl/average_frame_gen.sv | 164 ++++++++++++++++
 tb/tb_average_frame_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/average_frame_gen.sv
// -----------------------------------------------------------------------------
// average_frame_gen
//   Upstream framer for the averaging stage. Cuts a continuous stream of signed
//   samples into frames of N samples tagged with sof/eof/valid, and discards
//   whole samples while the averager is busy (between eof and its ready rising).
//
// Optional feature macro: AVG_FRAME_DROPCNT_EN
//   defined   -> drop_count counts discarded samples, saturating at 16'hFFFF
//   undefined -> drop_count tied to 16'h0000, no counter logic
//   Framing behaviour is identical either way.
//
// Ports
//   clk            : single clock, all state on its rising edge
//   rst            : synchronous active-high reset
//   cfg_frame_len  : requested frame length N (0 = default, >max clamps)
//   cfg_load       : 1-cycle strobe staging cfg_frame_len
//   din/din_valid  : sample stream, no backpressure
//   DATA_out       : registered sample (holds when DATA_out_valid is low)
//   DATA_out_valid : DATA_out qualifier
//   DATA_sof/eof   : first/last sample of frame, only with DATA_out_valid
//   DATA_in_ready  : averager ready
//   frame_len      : N in use for the current/next frame
//   drop_count     : discarded samples (see macro above)
//   frame_active   : high while a frame is being forwarded
// -----------------------------------------------------------------------------
module average_frame_gen #(
  parameter int C_DATA_WIDTH      = 54,
  parameter int MAX_FRAME_LEN     = 1001,
  parameter int DEFAULT_FRAME_LEN = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [9:0]              cfg_frame_len,
  input  logic                    cfg_load,
  input  logic [C_DATA_WIDTH-1:0] din,
  input  logic                    din_valid,
  output logic [C_DATA_WIDTH-1:0] DATA_out,
  output logic                    DATA_out_valid,
  output logic                    DATA_sof,
  output logic                    DATA_eof,
  input  logic                    DATA_in_ready,
  output logic [9:0]              frame_len,
  output logic [15:0]             drop_count,
  output logic                    frame_active
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_WAIT   = 2'd3;

  localparam logic [9:0] DEF_LEN = 10'(DEFAULT_FRAME_LEN);
  localparam logic [9:0] MAX_LEN = 10'(MAX_FRAME_LEN);

  // Map a requested length onto the legal range: 0 picks the default, oversize clamps.
  function automatic logic [9:0] resolve_len(input logic [9:0] req);
    logic [9:0] res;
    if (req == 10'd0) begin
      res = DEF_LEN;
    end else if (req > MAX_LEN) begin
      res = MAX_LEN;
    end else begin
      res = req;
    end
    return res;
  endfunction

  logic [1:0] state_r;
  logic [1:0] state_next_s;
  logic [9:0] count_r;
  logic [9:0] staged_len_r;
  logic [9:0] next_len_s;
  logic       start_s;
  logic       fwd_s;
  logic       last_s;

  // A load coinciding with a frame start applies to that very frame.
  assign next_len_s = cfg_load ? resolve_len(cfg_frame_len) : resolve_len(staged_len_r);

  // Next-state and per-cycle forwarding decisions.
  always_comb begin
    state_next_s = state_r;
    start_s      = 1'b0;
    fwd_s        = 1'b0;
    last_s       = 1'b0;
    case (state_r)
      ST_IDLE, ST_WAIT: begin
        if (DATA_in_ready) begin
          state_next_s = ST_RUN;
          start_s      = 1'b1;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_RUN: begin
        // Ready is ignored here: a started frame always runs to completion.
        if (din_valid) begin
          fwd_s = 1'b1;
          if (count_r == frame_len - 10'd1) begin
            last_s       = 1'b1;
            state_next_s = ST_SETTLE;
          end else begin
            last_s = 1'b0;
          end
        end else begin
          fwd_s = 1'b0;
        end
      end
      // The averager's ready is not trustworthy in the cycle right after eof.
      ST_SETTLE: state_next_s = ST_WAIT;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // FSM, frame counter, configuration staging and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      count_r        <= 10'd0;
      staged_len_r   <= 10'd0;
      frame_len      <= DEF_LEN;
      DATA_out       <= '0;
      DATA_out_valid <= 1'b0;
      DATA_sof       <= 1'b0;
      DATA_eof       <= 1'b0;
      frame_active   <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      frame_active <= (state_next_s == ST_RUN);
      if (cfg_load) begin
        staged_len_r <= cfg_frame_len;
      end
      if (start_s) begin
        frame_len <= next_len_s;
        count_r   <= 10'd0;
      end else if (fwd_s) begin
        count_r <= count_r + 10'd1;
      end
      DATA_out_valid <= fwd_s;
      DATA_sof       <= fwd_s && (count_r == 10'd0);
      DATA_eof       <= last_s;
      if (fwd_s) begin
        DATA_out <= din;
      end
    end
  end

`ifdef AVG_FRAME_DROPCNT_EN
  logic drop_s;
  assign drop_s = din_valid && (state_r != ST_RUN);

  // Saturating count of samples discarded outside RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= 16'h0000;
    end else if (drop_s && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'h0001;
    end
  end
`else
  assign drop_count = 16'h0000;
`endif

endmodule

// File: tb/tb_average_frame_gen.sv
// -----------------------------------------------------------------------------
// tb_average_frame_gen
//   Directed sequence with randomized data/strobes. A frame-level reference
//   model (accepting flag, position in frame, guard cycles after the last
//   sample) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_average_frame_gen;

  localparam int W = 54;

  logic         clk = 1'b0;
  logic         rst;
  logic [9:0]   cfg_frame_len;
  logic         cfg_load;
  logic [W-1:0] din;
  logic         din_valid;
  logic [W-1:0] DATA_out;
  logic         DATA_out_valid;
  logic         DATA_sof;
  logic         DATA_eof;
  logic         DATA_in_ready;
  logic [9:0]   frame_len;
  logic [15:0]  drop_count;
  logic         frame_active;

  average_frame_gen dut (
    .clk(clk), .rst(rst), .cfg_frame_len(cfg_frame_len), .cfg_load(cfg_load),
    .din(din), .din_valid(din_valid), .DATA_out(DATA_out),
    .DATA_out_valid(DATA_out_valid), .DATA_sof(DATA_sof), .DATA_eof(DATA_eof),
    .DATA_in_ready(DATA_in_ready), .frame_len(frame_len),
    .drop_count(drop_count), .frame_active(frame_active)
  );

  always #5 clk = ~clk;

  int total = 0;
  int fails = 0;

  // Reference model state
  bit           m_acc;
  int           m_guard;
  int           m_pos;
  int           m_n;
  int           m_staged;
  int           m_drops;
  logic [W-1:0] m_data;
  bit           m_valid, m_sof, m_eof;

  // Observation counters
  int           n_valid;
  logic [W-1:0] sof_data, eof_data;

  function automatic int resolve(input int v);
    if (v == 0) return 1000;
    if (v > 1001) return 1001;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_acc = 0; m_guard = 0; m_pos = 0; m_n = 1000; m_staged = 0; m_drops = 0;
      m_data = '0; m_valid = 0; m_sof = 0; m_eof = 0;
    end else begin
      m_valid = 0; m_sof = 0; m_eof = 0;
      if (m_acc) begin
        if (din_valid) begin
          m_valid = 1;
          m_data  = din;
          m_sof   = (m_pos == 0);
          m_eof   = (m_pos == m_n - 1);
          m_pos++;
          if (m_eof) begin
            m_acc   = 0;
            m_guard = 1;
          end
        end
      end else begin
        if (din_valid && m_drops < 65535) m_drops++;
        if (m_guard > 0) begin
          m_guard--;
        end else if (DATA_in_ready) begin
          m_acc = 1;
          m_pos = 0;
          m_n   = resolve(cfg_load ? int'(cfg_frame_len) : m_staged);
        end
      end
      if (cfg_load) m_staged = int'(cfg_frame_len);
    end
  endtask

  task automatic cyc();
    int exp_drops;
    @(posedge clk);
    model_step();
    #1;
`ifdef AVG_FRAME_DROPCNT_EN
    exp_drops = m_drops;
`else
    exp_drops = 0;
`endif
    chk("valid", 64'(DATA_out_valid), 64'(m_valid));
    chk("sof", 64'(DATA_sof), 64'(m_sof));
    chk("eof", 64'(DATA_eof), 64'(m_eof));
    chk("data", 64'(DATA_out), 64'(m_data));
    chk("frame_len", 64'(frame_len), 64'(m_n));
    chk("active", 64'(frame_active), 64'(m_acc));
    chk("drop_count", 64'(drop_count), 64'(exp_drops));
    if (DATA_out_valid) begin
      n_valid++;
      if (DATA_sof) sof_data = DATA_out;
      if (DATA_eof) eof_data = DATA_out;
    end
  endtask

  task automatic rnd_din();
    din = {$urandom, $urandom};
  endtask

  initial begin
    bit seen;
    rst = 1'b1; cfg_frame_len = 10'd0; cfg_load = 1'b0;
    din = '0; din_valid = 1'b0; DATA_in_ready = 1'b1;
    n_valid = 0; sof_data = '0; eof_data = '0;

    // Reset state
    cyc(); cyc();
    chk("rst_len", 64'(frame_len), 64'd1000);
    chk("rst_valid", 64'(DATA_out_valid), 64'd0);

    // 1: default N=1000, ramp 0..999
    rst = 1'b0;
    cyc();
    for (int i = 0; i < 1000; i++) begin
      din = W'(i); din_valid = 1'b1;
      cyc();
    end
    din_valid = 1'b0;
    cyc();
    chk("t1_valids", 64'(n_valid), 64'd1000);
    chk("t1_sof_data", 64'(sof_data), 64'd0);
    chk("t1_eof_data", 64'(eof_data), 64'd999);

    // 2: load len=4 mid-frame of 1000
    din_valid = 1'b1;
    for (int i = 0; i < 1100; i++) begin
      rnd_din();
      cfg_load = (i == 300);
      cfg_frame_len = 10'd4;
      cyc();
    end
    cfg_load = 1'b0;
    chk("t2_len", 64'(frame_len), 64'd4);

    // 3: ready low for 20 cycles after eof
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      rnd_din();
      cyc();
      if (DATA_out_valid && DATA_eof) seen = 1;
    end
    chk("t3_eof_seen", 64'(seen), 64'd1);
    DATA_in_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rnd_din();
      cyc();
    end
    DATA_in_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rnd_din();
      din_valid = 1'($urandom_range(0, 3) != 0);
      cyc();
    end

    // 4: len=1, then 0 -> 1000, then 1023 -> 1001
    cfg_frame_len = 10'd1; cfg_load = 1'b1;
    cyc();
    cfg_load = 1'b0;
    for (int i = 0; i < 60; i++) begin
      rnd_din();
      din_valid = 1'($urandom_range(0, 1));
      DATA_in_ready = 1'($urandom_range(0, 3) != 0);
      cyc();
    end
    DATA_in_ready = 1'b1;
    din_valid = 1'b1;
    cfg_frame_len = 10'd0; cfg_load = 1'b1;
    cyc();
    cfg_load = 1'b0;
    for (int i = 0; i < 10; i++) begin rnd_din(); cyc(); end
    chk("t4_len0", 64'(frame_len), 64'd1000);
    cfg_frame_len = 10'd1023; cfg_load = 1'b1;
    cyc();
    cfg_load = 1'b0;
    for (int i = 0; i < 1010; i++) begin rnd_din(); cyc(); end
    chk("t4_len1023", 64'(frame_len), 64'd1001);

    // 5: reset at sample 500 of a 1001-sample frame
    for (int i = 0; i < 500; i++) begin rnd_din(); cyc(); end
    rst = 1'b1;
    cyc();
    chk("t5_valid", 64'(DATA_out_valid), 64'd0);
    chk("t5_eof", 64'(DATA_eof), 64'd0);
    chk("t5_data", 64'(DATA_out), 64'd0);
    rst = 1'b0;
    n_valid = 0;
    for (int i = 0; i < 30; i++) begin rnd_din(); cyc(); end
    chk("t5_restart", 64'(n_valid > 0), 64'd1);

    // 6: negative samples, then long drop run
    din = '1;
    for (int i = 0; i < 5; i++) cyc();
    chk("t6_neg", 64'(DATA_out), 64'h003F_FFFF_FFFF_FFFF);
    DATA_in_ready = 1'b0;
    for (int i = 0; i < 71500; i++) begin
      din = W'(i);
      cyc();
    end
`ifdef AVG_FRAME_DROPCNT_EN
    chk("t6_sat", 64'(drop_count), 64'hFFFF);
`else
    chk("t6_sat", 64'(drop_count), 64'h0);
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
